// File: rtl/mt_ckpt_pkg.sv
// Shared definitions for the checkpointed rename map table.
//  - ALU operand-select encodings used by decode to derive id_use_ra/id_use_rb
//  - default register-file geometry (PR tag width, AR count/index width)
//  - mt_entry_t: one map-table entry as {tag, ready}
//  - `SD: register-update delay hook, empty for RTL and synthesis

`ifndef SD
`define SD
`endif

package mt_ckpt_pkg;

    // Operand A/B select values meaning "read the register file".
    localparam logic [1:0] ALU_OPA_IS_REGA = 2'h0;
    localparam logic [1:0] ALU_OPB_IS_REGB = 2'h0;

    localparam int unsigned PRW_DEF    = 7;
    localparam int unsigned NUM_AR_DEF = 32;
    localparam int unsigned ARW_DEF    = $clog2(NUM_AR_DEF);

    typedef struct packed {
        logic [PRW_DEF-1:0] tag;
        logic               ready;
    } mt_entry_t;

endpackage

// File: rtl/mt_ckpt_bank.sv
// Branch checkpoint storage for the rename map table.
// Holds NUM_CKPT snapshots of the live map (tags + ready bits), their valid
// bits and the head/tail allocation pointers. CDB broadcasts keep the ready
// bits of every valid snapshot current. Exposes the selected snapshot (with
// this cycle's CDB wakeups folded in) for single-cycle mispredict restore.
// Ports:
//  clock, reset            clock, synchronous active-high reset
//  flush                   exception recovery: drop all checkpoints
//  cdb_valid/pr/ar         CDB broadcast channels
//  take                    write snap_map/snap_rdy into entry tail
//  snap_map, snap_rdy      snapshot to store (flattened AR-indexed)
//  br_valid/ckpt/mispredict branch resolution
//  ckpt_id, ckpt_full      tail pointer, all entries valid
//  res_map, res_rdy        restore image of entry br_ckpt

module mt_ckpt_bank
    import mt_ckpt_pkg::*;
#(
    parameter int unsigned CDB_W    = 6,
    parameter int unsigned NUM_AR   = NUM_AR_DEF,
    parameter int unsigned PRW      = PRW_DEF,
    parameter int unsigned NUM_CKPT = 4,
    localparam int unsigned ARW     = $clog2(NUM_AR),
    localparam int unsigned CKW     = $clog2(NUM_CKPT)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [CDB_W-1:0]        cdb_valid,
    input  logic [CDB_W*PRW-1:0]    cdb_pr,
    input  logic [CDB_W*ARW-1:0]    cdb_ar,
    input  logic                    take,
    input  logic [NUM_AR*PRW-1:0]   snap_map,
    input  logic [NUM_AR-1:0]       snap_rdy,
    input  logic                    br_valid,
    input  logic [CKW-1:0]          br_ckpt,
    input  logic                    br_mispredict,
    output logic [CKW-1:0]          ckpt_id,
    output logic                    ckpt_full,
    output logic [NUM_AR*PRW-1:0]   res_map,
    output logic [NUM_AR-1:0]       res_rdy
);

    logic [NUM_AR*PRW-1:0] cmap_q [NUM_CKPT];
    logic [NUM_AR-1:0]     crdy_q [NUM_CKPT];
    logic [NUM_AR-1:0]     crdy_w [NUM_CKPT];
    logic [NUM_AR-1:0]     crdy_d [NUM_CKPT];
    logic [NUM_CKPT-1:0]   val_q, val_d;
    logic [CKW-1:0]        head_q, head_d, tail_q, tail_d;

    assign ckpt_id   = tail_q;
    assign ckpt_full = &val_q;

    // CDB wakeup applied to every valid snapshot.
    always_comb begin
        for (int e = 0; e < NUM_CKPT; e++) begin
            crdy_w[e] = crdy_q[e];
            for (int c = 0; c < CDB_W; c++) begin
                if (val_q[e] && cdb_valid[c] &&
                    cmap_q[e][cdb_ar[c*ARW +: ARW]*PRW +: PRW] == cdb_pr[c*PRW +: PRW]) begin
                    crdy_w[e][cdb_ar[c*ARW +: ARW]] = 1'b1;
                end
            end
        end
        res_map = cmap_q[br_ckpt];
        res_rdy = crdy_w[br_ckpt];
    end

    always_comb begin
        logic [CKW-1:0] off_e;
        logic [CKW-1:0] off_b;
        val_d  = val_q;
        tail_d = tail_q;
        crdy_d = crdy_w;
        off_e  = '0;
        off_b  = br_ckpt - head_q;
        if (flush) begin
            val_d  = '0;
            tail_d = '0;
        end else if (br_valid && br_mispredict) begin
            // Age is measured from head; the mispredicted entry and everything
            // allocated after it are squashed.
            for (int e = 0; e < NUM_CKPT; e++) begin
                off_e = CKW'(e) - head_q;
                if (off_e >= off_b) val_d[e] = 1'b0;
            end
            tail_d = br_ckpt;
        end else begin
            if (br_valid) val_d[br_ckpt] = 1'b0;
            if (take) begin
                val_d[tail_q]  = 1'b1;
                crdy_d[tail_q] = snap_rdy;
                tail_d         = tail_q + 1'b1;
            end
        end

        // Head skips resolved entries; with nothing live it parks on tail.
        head_d = head_q;
        if (flush) begin
            head_d = '0;
        end else if (val_d == '0) begin
            head_d = tail_d;
        end else begin
            for (int k = 0; k < NUM_CKPT; k++) begin
                if (!val_d[head_d]) head_d = head_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            val_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < NUM_CKPT; e++) crdy_q[e] <= '0;
        end else begin
            val_q  <= val_d;
            head_q <= head_d;
            tail_q <= tail_d;
            crdy_q <= crdy_d;
        end
    end

    // Tag storage needs no reset: entries are qualified by val_q.
    always_ff @(posedge clock) begin
        if (!reset && !flush && !(br_valid && br_mispredict) && take) begin
            cmap_q[tail_q] <= snap_map;
        end
    end

endmodule

// File: rtl/mt_ckpt.sv
// Rename-stage register map table with branch checkpoints.
// Combinationally renames DW lanes per cycle (source tags, ready bits and the
// old dest mapping), with intra-bundle bypass from older lanes. Tracks ready
// bits from CDB broadcasts, keeps a retirement map for exception recovery and
// restores a branch checkpoint in one cycle on mispredict.
// Ports:
//  clock, reset                synchronous active-high reset
//  id_*                        decoded bundle (lane-packed), id_dispatch commits
//  fl_pr                       new PR per lane
//  cdb_*                       CDB broadcast channels
//  br_*                        branch resolution
//  recover                     exception restore from retired map
//  rob_retire/ret_ar/ret_pr    retiring mappings
//  rob_told                    previous mapping of each lane's dest
//  rs_pr_a/b, rs_rdy_a/b       renamed source tags and readiness
//  ckpt_id, ckpt_full          checkpoint allocation status

module mt_ckpt
    import mt_ckpt_pkg::*;
#(
    parameter int unsigned DW       = 2,
    parameter int unsigned CDB_W    = 6,
    parameter int unsigned NUM_AR   = NUM_AR_DEF,
    parameter int unsigned PRW      = PRW_DEF,
    parameter int unsigned NUM_CKPT = 4,
    localparam int unsigned ARW     = $clog2(NUM_AR),
    localparam int unsigned CKW     = $clog2(NUM_CKPT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DW-1:0]         id_valid,
    input  logic                  id_dispatch,
    input  logic [DW-1:0]         id_use_ra,
    input  logic [DW-1:0]         id_use_rb,
    input  logic [DW*ARW-1:0]     id_ra,
    input  logic [DW*ARW-1:0]     id_rb,
    input  logic [DW*ARW-1:0]     id_dest,
    input  logic [DW-1:0]         id_branch,
    input  logic [DW*PRW-1:0]     fl_pr,
    input  logic [CDB_W-1:0]      cdb_valid,
    input  logic [CDB_W*PRW-1:0]  cdb_pr,
    input  logic [CDB_W*ARW-1:0]  cdb_ar,
    input  logic                  br_valid,
    input  logic [CKW-1:0]        br_ckpt,
    input  logic                  br_mispredict,
    input  logic                  recover,
    input  logic [DW-1:0]         rob_retire,
    input  logic [DW*ARW-1:0]     rob_ret_ar,
    input  logic [DW*PRW-1:0]     rob_ret_pr,
    output logic [DW*PRW-1:0]     rob_told,
    output logic [DW*PRW-1:0]     rs_pr_a,
    output logic [DW*PRW-1:0]     rs_pr_b,
    output logic [DW-1:0]         rs_rdy_a,
    output logic [DW-1:0]         rs_rdy_b,
    output logic [CKW-1:0]        ckpt_id,
    output logic                  ckpt_full
);

    logic [PRW-1:0]        map_q [NUM_AR];
    logic [PRW-1:0]        map_d [NUM_AR];
    logic [PRW-1:0]        map_w [NUM_AR];
    logic [PRW-1:0]        snap_arr [NUM_AR];
    logic [PRW-1:0]        ret_q [NUM_AR];
    logic [PRW-1:0]        ret_d [NUM_AR];
    logic [NUM_AR-1:0]     rdy_q, rdy_d, rdy_w;
    logic [NUM_AR*PRW-1:0] snap_map, res_map;
    logic [NUM_AR-1:0]     snap_rdy, res_rdy;
    logic                  mispredict, normal, take;

    assign mispredict = br_valid && br_mispredict && !recover;
    assign normal     = !recover && !mispredict;
    assign take       = normal && id_dispatch && |(id_valid & id_branch) && !ckpt_full;

    // Rename lookup: current map, overridden by the youngest older lane in
    // the bundle writing the same AR.
    always_comb begin
        logic [ARW-1:0] ra, rb, dst, di;
        logic [PRW-1:0] pa, pb, pt;
        logic           ya, yb;
        rob_told = '0;
        rs_pr_a  = '0;
        rs_pr_b  = '0;
        rs_rdy_a = '0;
        rs_rdy_b = '0;
        for (int j = 0; j < DW; j++) begin
            ra  = id_ra[j*ARW +: ARW];
            rb  = id_rb[j*ARW +: ARW];
            dst = id_dest[j*ARW +: ARW];
            pa  = map_q[ra];
            ya  = rdy_q[ra];
            pb  = map_q[rb];
            yb  = rdy_q[rb];
            pt  = map_q[dst];
            for (int i = 0; i < DW; i++) begin
                di = id_dest[i*ARW +: ARW];
                if (i < j && id_valid[i]) begin
                    if (di == ra) begin
                        pa = fl_pr[i*PRW +: PRW];
                        ya = 1'b0;
                    end
                    if (di == rb) begin
                        pb = fl_pr[i*PRW +: PRW];
                        yb = 1'b0;
                    end
                    if (di == dst) pt = fl_pr[i*PRW +: PRW];
                end
            end
            if (!id_valid[j] || !id_use_ra[j]) ya = 1'b1;
            if (!id_valid[j] || !id_use_rb[j]) yb = 1'b1;
            rs_pr_a[j*PRW +: PRW]  = pa;
            rs_pr_b[j*PRW +: PRW]  = pb;
            rob_told[j*PRW +: PRW] = pt;
            rs_rdy_a[j]            = ya;
            rs_rdy_b[j]            = yb;
        end
    end

    // Next-state for live, retired and snapshot images.
    always_comb begin
        logic [ARW-1:0] a;
        ret_d = ret_q;
        for (int k = 0; k < DW; k++) begin
            if (rob_retire[k]) ret_d[rob_ret_ar[k*ARW +: ARW]] = rob_ret_pr[k*PRW +: PRW];
        end

        // CDB first so a same-cycle dispatch to the AR wins.
        map_w = map_q;
        rdy_w = rdy_q;
        for (int c = 0; c < CDB_W; c++) begin
            a = cdb_ar[c*ARW +: ARW];
            if (cdb_valid[c] && map_q[a] == cdb_pr[c*PRW +: PRW]) rdy_w[a] = 1'b1;
        end
        snap_arr = map_w;
        snap_rdy = rdy_w;
        for (int j = 0; j < DW; j++) begin
            if (id_dispatch && id_valid[j]) begin
                a        = id_dest[j*ARW +: ARW];
                map_w[a] = fl_pr[j*PRW +: PRW];
                rdy_w[a] = 1'b0;
                if (id_branch[j]) begin
                    snap_arr = map_w;
                    snap_rdy = rdy_w;
                end
            end
        end
        for (int r = 0; r < NUM_AR; r++) snap_map[r*PRW +: PRW] = snap_arr[r];

        if (recover) begin
            map_d = ret_d;
            rdy_d = '1;
        end else if (mispredict) begin
            for (int r = 0; r < NUM_AR; r++) map_d[r] = res_map[r*PRW +: PRW];
            rdy_d = res_rdy;
        end else begin
            map_d = map_w;
            rdy_d = rdy_w;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_AR; r++) begin
                map_q[r] <= PRW'(r);
                ret_q[r] <= PRW'(r);
            end
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            ret_q <= ret_d;
            rdy_q <= rdy_d;
        end
    end

    mt_ckpt_bank #(
        .CDB_W    (CDB_W),
        .NUM_AR   (NUM_AR),
        .PRW      (PRW),
        .NUM_CKPT (NUM_CKPT)
    ) u_bank (
        .clock         (clock),
        .reset         (reset),
        .flush         (recover),
        .cdb_valid     (cdb_valid),
        .cdb_pr        (cdb_pr),
        .cdb_ar        (cdb_ar),
        .take          (take),
        .snap_map      (snap_map),
        .snap_rdy      (snap_rdy),
        .br_valid      (br_valid && !recover),
        .br_ckpt       (br_ckpt),
        .br_mispredict (br_mispredict),
        .ckpt_id       (ckpt_id),
        .ckpt_full     (ckpt_full),
        .res_map       (res_map),
        .res_rdy       (res_rdy)
    );

    // Decode must stall branch bundles while no checkpoint is free.
    branch_when_full_a: assert property (@(posedge clock) disable iff (reset)
        !(normal && id_dispatch && |(id_valid & id_branch) && ckpt_full));

endmodule

// File: tb/tb_mt_ckpt.sv
// Scoreboard bench for mt_ckpt: the driver pushes hand-computed expectations
// stamped with the cycle they apply to; a negedge monitor pops and compares.

module tb_mt_ckpt;
    import mt_ckpt_pkg::*;

    localparam int DW = 2, CDB_W = 6, PRW = 7, ARW = 5, CKW = 2;
    localparam logic [1:0] IMM = 2'h3;
    localparam int F_PRA = 0, F_RDYA = 1, F_PRB = 2, F_RDYB = 3, F_TOLD = 4;
    localparam int F_CKID = 5, F_FULL = 6;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [DW-1:0]        id_valid, id_use_ra, id_use_rb, id_branch;
    logic                 id_dispatch;
    logic [DW*ARW-1:0]    id_ra, id_rb, id_dest;
    logic [DW*PRW-1:0]    fl_pr;
    logic [CDB_W-1:0]     cdb_valid;
    logic [CDB_W*PRW-1:0] cdb_pr;
    logic [CDB_W*ARW-1:0] cdb_ar;
    logic                 br_valid, br_mispredict, recover;
    logic [CKW-1:0]       br_ckpt;
    logic [DW-1:0]        rob_retire;
    logic [DW*ARW-1:0]    rob_ret_ar;
    logic [DW*PRW-1:0]    rob_ret_pr;
    logic [DW*PRW-1:0]    rob_told, rs_pr_a, rs_pr_b;
    logic [DW-1:0]        rs_rdy_a, rs_rdy_b;
    logic [CKW-1:0]       ckpt_id;
    logic                 ckpt_full;

    mt_ckpt dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_dispatch(id_dispatch),
        .id_use_ra(id_use_ra), .id_use_rb(id_use_rb), .id_ra(id_ra), .id_rb(id_rb),
        .id_dest(id_dest), .id_branch(id_branch), .fl_pr(fl_pr), .cdb_valid(cdb_valid),
        .cdb_pr(cdb_pr), .cdb_ar(cdb_ar), .br_valid(br_valid), .br_ckpt(br_ckpt),
        .br_mispredict(br_mispredict), .recover(recover), .rob_retire(rob_retire),
        .rob_ret_ar(rob_ret_ar), .rob_ret_pr(rob_ret_pr), .rob_told(rob_told),
        .rs_pr_a(rs_pr_a), .rs_pr_b(rs_pr_b), .rs_rdy_a(rs_rdy_a), .rs_rdy_b(rs_rdy_b),
        .ckpt_id(ckpt_id), .ckpt_full(ckpt_full)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          fld;
        int          ln;
        logic [31:0] exp;
        string       nm;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t item;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] get_field(input int fld, input int ln);
        case (fld)
            F_PRA:   return 32'(rs_pr_a[ln*PRW +: PRW]);
            F_RDYA:  return 32'(rs_rdy_a[ln]);
            F_PRB:   return 32'(rs_pr_b[ln*PRW +: PRW]);
            F_RDYB:  return 32'(rs_rdy_b[ln]);
            F_TOLD:  return 32'(rob_told[ln*PRW +: PRW]);
            F_CKID:  return 32'(ckpt_id);
            default: return 32'(ckpt_full);
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            logic [31:0] act;
            item = sb.pop_front();
            act  = get_field(item.fld, item.ln);
            checks++;
            if (item.cyc != cyc || act !== item.exp) begin
                failures++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", item.nm, act, item.exp,
                         cyc);
            end
        end
    end

    function automatic mt_entry_t ent(input int pr, input bit rdy);
        mt_entry_t e;
        e.tag   = PRW'(pr);
        e.ready = rdy;
        return e;
    endfunction

    task automatic exp_v(input int fld, input int ln, input int v, input string nm);
        sb_item_t it;
        it.cyc = cyc;
        it.fld = fld;
        it.ln  = ln;
        it.exp = 32'(v);
        it.nm  = nm;
        sb.push_back(it);
    endtask

    task automatic exp_a(input int ln, input mt_entry_t e, input string nm);
        exp_v(F_PRA, ln, int'(e.tag), {nm, "_pra"});
        exp_v(F_RDYA, ln, int'(e.ready), {nm, "_rdya"});
    endtask

    task automatic exp_b(input int ln, input mt_entry_t e, input string nm);
        exp_v(F_PRB, ln, int'(e.tag), {nm, "_prb"});
        exp_v(F_RDYB, ln, int'(e.ready), {nm, "_rdyb"});
    endtask

    task automatic clear_inputs();
        id_valid = '0; id_dispatch = 1'b0; id_use_ra = '0; id_use_rb = '0;
        id_ra = '0; id_rb = '0; id_dest = '0; id_branch = '0; fl_pr = '0;
        cdb_valid = '0; cdb_pr = '0; cdb_ar = '0;
        br_valid = 1'b0; br_ckpt = '0; br_mispredict = 1'b0; recover = 1'b0;
        rob_retire = '0; rob_ret_ar = '0; rob_ret_pr = '0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic set_lane(input int j, input logic [1:0] opa, input int ra,
                            input logic [1:0] opb, input int rb, input int dest,
                            input int fl, input bit br);
        id_valid[j]            = 1'b1;
        id_use_ra[j]           = (opa == ALU_OPA_IS_REGA);
        id_use_rb[j]           = (opb == ALU_OPB_IS_REGB);
        id_ra[j*ARW +: ARW]    = ARW'(ra);
        id_rb[j*ARW +: ARW]    = ARW'(rb);
        id_dest[j*ARW +: ARW]  = ARW'(dest);
        fl_pr[j*PRW +: PRW]    = PRW'(fl);
        id_branch[j]           = br;
    endtask

    task automatic cdb(input int ch, input int pr, input int ar);
        cdb_valid[ch]          = 1'b1;
        cdb_pr[ch*PRW +: PRW]  = PRW'(pr);
        cdb_ar[ch*ARW +: ARW]  = ARW'(ar);
    endtask

    task automatic retire(input int k, input int ar, input int pr);
        rob_retire[k]              = 1'b1;
        rob_ret_ar[k*ARW +: ARW]   = ARW'(ar);
        rob_ret_pr[k*PRW +: PRW]   = PRW'(pr);
    endtask

    task automatic resolve(input int id, input bit misp);
        br_valid      = 1'b1;
        br_ckpt       = CKW'(id);
        br_mispredict = misp;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Identity map after reset.
        set_lane(0, ALU_OPA_IS_REGA, 5, ALU_OPB_IS_REGB, 0, 0, 0, 0);
        exp_a(0, ent(5, 1), "rst_r5");
        exp_b(0, ent(0, 1), "rst_r0");
        exp_v(F_RDYA, 1, 1, "idle_lane_rdy");
        exp_v(F_CKID, 0, 0, "rst_ckpt_id");
        exp_v(F_FULL, 0, 0, "rst_full");
        #1;
        checks++;
        if (rs_pr_a[PRW-1:0] !== 7'd5) begin
            failures++;
            $display("FAIL direct_rst_pra: got %0d expected 5", rs_pr_a[PRW-1:0]);
        end
        checks++;
        if (rs_rdy_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL direct_rst_rdya: got %0d expected 1", rs_rdy_a[0]);
        end
        checks++;
        if (ckpt_full !== 1'b0) begin
            failures++;
            $display("FAIL direct_rst_full: got %0d expected 0", ckpt_full);
        end

        // Intra-bundle bypass, same dest in both lanes.
        next();
        set_lane(0, ALU_OPA_IS_REGA, 1, IMM, 0, 3, 40, 0);
        set_lane(1, ALU_OPA_IS_REGA, 3, IMM, 3, 3, 41, 0);
        id_dispatch = 1'b1;
        exp_a(0, ent(1, 1), "l0_r1");
        exp_a(1, ent(40, 0), "bypass_r3");
        exp_v(F_PRB, 1, 40, "bypass_unused_prb");
        exp_v(F_RDYB, 1, 1, "unused_rdyb");
        exp_v(F_TOLD, 0, 3, "told_l0");
        exp_v(F_TOLD, 1, 40, "told_l1_bypass");

        // Youngest lane wins; stale CDB tag ignored.
        next();
        set_lane(0, ALU_OPA_IS_REGA, 3, IMM, 0, 0, 0, 0);
        cdb(0, 40, 3);
        exp_a(0, ent(41, 0), "map3_41");
        next();
        set_lane(0, ALU_OPA_IS_REGA, 3, IMM, 0, 0, 0, 0);
        cdb(5, 41, 3);
        exp_a(0, ent(41, 0), "stale_cdb");
        next();
        set_lane(0, ALU_OPA_IS_REGA, 3, IMM, 0, 0, 0, 0);
        exp_a(0, ent(41, 1), "cdb_wakeup");

        // Branch on lane 0 then mispredict back to it.
        next();
        set_lane(0, IMM, 0, IMM, 0, 4, 50, 1);
        set_lane(1, IMM, 0, IMM, 0, 4, 51, 0);
        id_dispatch = 1'b1;
        exp_v(F_CKID, 0, 0, "br_ckpt_id0");
        exp_v(F_TOLD, 1, 50, "br_told_l1");
        next();
        set_lane(0, ALU_OPA_IS_REGA, 4, IMM, 0, 5, 55, 0);
        id_dispatch = 1'b1;
        resolve(0, 1);
        exp_a(0, ent(51, 0), "live_r4");
        exp_v(F_CKID, 0, 1, "tail_after_br");
        next();
        set_lane(0, ALU_OPA_IS_REGA, 4, ALU_OPB_IS_REGB, 5, 0, 0, 0);
        cdb(2, 50, 4);
        exp_a(0, ent(50, 0), "misp_r4");
        exp_b(0, ent(5, 1), "misp_disp_ignored");
        exp_v(F_CKID, 0, 0, "misp_tail");

        // Fill all checkpoints.
        for (int k = 0; k < 4; k++) begin
            next();
            set_lane(0, ALU_OPA_IS_REGA, 4, IMM, 0, 10 + k, 70 + k, 1);
            id_dispatch = 1'b1;
            exp_v(F_CKID, 0, k, "fill_id");
            exp_v(F_FULL, 0, 0, "fill_not_full");
            if (k == 0) exp_a(0, ent(50, 1), "r4_woken");
        end
        next();
        resolve(0, 0);
        exp_v(F_FULL, 0, 1, "full");
        exp_v(F_CKID, 0, 0, "full_id_wrap");
        next();
        cdb(1, 71, 11);
        exp_v(F_FULL, 0, 0, "resolve_frees");

        // Mispredict a middle checkpoint; snapshot saw the CDB wakeup.
        next();
        resolve(2, 1);
        exp_v(F_CKID, 0, 0, "pre_misp_tail");
        next();
        set_lane(0, ALU_OPA_IS_REGA, 11, ALU_OPB_IS_REGB, 12, 0, 0, 0);
        set_lane(1, ALU_OPA_IS_REGA, 13, IMM, 0, 0, 0, 0);
        exp_a(0, ent(71, 1), "ckpt_cdb_r11");
        exp_b(0, ent(72, 0), "ckpt_r12");
        exp_a(1, ent(13, 1), "ckpt_r13");
        exp_v(F_CKID, 0, 2, "misp_mid_tail");

        // Retire then recover (same-cycle retires included).
        next();
        retire(0, 7, 59);
        retire(1, 7, 60);
        next();
        recover = 1'b1;
        retire(0, 8, 62);
        retire(1, 9, 63);
        set_lane(0, IMM, 0, IMM, 0, 9, 90, 1);
        id_dispatch = 1'b1;
        cdb(0, 90, 9);
        next();
        set_lane(0, ALU_OPA_IS_REGA, 7, ALU_OPB_IS_REGB, 8, 0, 0, 0);
        set_lane(1, ALU_OPA_IS_REGA, 9, ALU_OPB_IS_REGB, 4, 0, 0, 0);
        exp_a(0, ent(60, 1), "rec_r7");
        exp_b(0, ent(62, 1), "rec_r8");
        exp_a(1, ent(63, 1), "rec_r9");
        exp_b(1, ent(4, 1), "rec_r4");
        exp_v(F_CKID, 0, 0, "rec_ckpt_id");
        exp_v(F_FULL, 0, 0, "rec_full");
        #1;
        checks++;
        if (rs_pr_a[PRW-1:0] !== 7'd60) begin
            failures++;
            $display("FAIL direct_rec_r7: got %0d expected 60", rs_pr_a[PRW-1:0]);
        end
        checks++;
        if (rs_rdy_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL direct_rec_rdy: got %0d expected 1", rs_rdy_a[0]);
        end

        next();
        next();
        while (sb.size() > 0) begin
            item = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: never compared, expected %0d", item.nm, item.exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
